multi_sel_rx: RTL
=================

# multi_sel_rx

Receiver for the `multi_sel` output stream. `multi_sel` emits each accepted 8-bit operand as a 4-sample frame on an 11-bit bus: d×1, d×3, d×7, d×8. `input_grant` marks the first sample of each frame. This block realigns to those frames, recovers `d`, and checks the three remaining samples against shift-add expectations. It reports one result per frame and keeps a saturating error count. It sits at the far end of the link, and the bench uses it as the checker for `multi_sel`.

## Interface
- `ERR_CNT_W`, default 8, width of the saturating error counter.
- `clk`, in, 1, single clock, rising edge.
- `rst`, in, 1, asynchronous active-low reset.
- `input_grant`, in, 1, frame-start strobe; high for exactly the d×1 sample cycle.
- `din`, in, 11, sample bus; registered output of the sender.
- `d_out`, out, 8, recovered operand; held until the next result.
- `d_valid`, out, 1, one-cycle pulse per completed or aborted frame.
- `err`, out, 1, qualifies `d_valid`; 1 means a mismatch, truncated frame or overrange first sample.
- `err_cnt`, out, `ERR_CNT_W`, count of `d_valid` pulses with `err`=1; saturates at all-ones.

## Operation
- States: IDLE, then P1, P2, P3 (the sample index expected next).
- In any state, `input_grant`=1 does all of the following:
  - capture `din[7:0]` into `d_cap`;
  - set the frame-error flag if `din[10:8]`≠0;
  - go to P1.
- P1 expects (d_cap<<1)+d_cap. P2 expects (d_cap<<3)−d_cap. P3 expects d_cap<<3.
- All expected values are computed at 11 bits. There is no overflow, since the maximum is 2040.
- In each of P1, P2 and P3, a mismatch sets the frame-error flag (OR-accumulated).
- After the P3 compare the state goes to IDLE. Next cycle: `d_valid`=1, `d_out`=`d_cap`, `err`=flag.
- In IDLE, samples without `input_grant` are ignored and produce no output.
- Early grant (grant seen in P1, P2 or P3):
  - next cycle `d_valid`=1 with `err`=1 and `d_out`=old `d_cap`;
  - that same grant cycle captures the new frame, which is processed normally.
- If the P3 sample's result pulse and a new grant coincide, both are handled; no cycle is lost.
- `err_cnt` increments on each `d_valid`&&`err` and holds at 2^ERR_CNT_W−1.

## Timing
- Reset values:
  - state IDLE;
  - `d_out`=0, `d_valid`=0, `err`=0, `err_cnt`=0;
  - `d_cap`=0 and frame flag cleared.
- Reset is asynchronous assert and synchronous release. A frame in flight at reset is discarded with no `d_valid`.
- Latency: grant at cycle T (d×1 sample), then P1/P2/P3 samples at T+1..T+3, then `d_valid` at T+4.
- Back-to-back frames (grant every 4 cycles) give one `d_valid` every 4 cycles, with no bubbles.
- Truncated frame with grant at T+k (k=1..3): `d_valid`/`err`=1 at T+k+1.
- All outputs are registered. `din` and `input_grant` are sampled only on the rising `clk` edge.

## Structure
- Package `multi_sel_pkg` holds:
  - state encoding `ms_phase_t` (IDLE, P1, P2, P3);
  - `MS_FRAME_LEN`=4;
  - `MS_DIN_W`=11 and `MS_D_W`=8;
  - the factor constants 1, 3, 7, 8.
- One sub-module, `multi_sel_expect`: combinational, shift-add only (no `*` operator). Inputs `d_cap` and phase; output the 11-bit expected sample.
- Top level holds the FSM, capture register, flag, output registers and counter.

## Test plan
- Clean frame for d=5: grant with samples 5, 15, 35, 40. Expect `d_valid` 4 cycles after grant, `d_out`=5, `err`=0, `err_cnt`=0.
- Back-to-back frames for d=7 (7, 21, 49, 56) then d=255 (255, 765, 1785, 2040). Expect two pulses 4 cycles apart, `d_out`=7 then 255, both with `err`=0.
- Corrupted frame for d=6: samples 6, 18, 41, 48. Expect `d_out`=6, `err`=1, `err_cnt`=1.
- Early grant: frame for d=6 is cut after 6, 18, and a grant arrives with d=1 (then 1, 3, 7, 8).
  - Expect a pulse with `d_out`=6, `err`=1, one cycle after the second grant.
  - Then `d_out`=1, `err`=0, 4 cycles after that grant.
- Idle noise and overrange first sample:
  - `din` toggling with no grant gives no `d_valid`.
  - Grant with `din`=11'h105, then samples 15, 35, 40, gives `err`=1 with `d_out`=5.
- Reset mid-frame: assert `rst`=0 in P2. Outputs go to 0 immediately, `err_cnt`=0, and no pulse is emitted. A later clean frame for d=5 gives `err`=0.

Source files
------------

// File: rtl/multi_sel_pkg.sv
// rtl/multi_sel_pkg.sv - shared types and constants for the multi_sel frame receiver
package multi_sel_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_P1   = 2'd1,
    MS_P2   = 2'd2,
    MS_P3   = 2'd3
  } ms_phase_t;

  localparam int MS_FRAME_LEN = 4;
  localparam int MS_DIN_W     = 11;
  localparam int MS_D_W       = 8;

  // Per-sample multipliers of the sender, in frame order.
  localparam int MS_K0 = 1;
  localparam int MS_K1 = 3;
  localparam int MS_K2 = 7;
  localparam int MS_K3 = 8;

endpackage

// File: rtl/multi_sel_expect.sv
// rtl/multi_sel_expect.sv - shift-add expected sample for the next frame phase
module multi_sel_expect
  import multi_sel_pkg::*;
(
  input  logic [MS_D_W-1:0]   d_cap,
  input  ms_phase_t           phase,
  output logic [MS_DIN_W-1:0] expect_val
);

  logic [MS_DIN_W-1:0] d_ext;

  assign d_ext = {{(MS_DIN_W - MS_D_W){1'b0}}, d_cap};

  always_comb begin
    expect_val = d_ext;
    case (phase)
      MS_P1:   expect_val = (d_ext << 1) + d_ext;
      MS_P2:   expect_val = (d_ext << 3) - d_ext;
      MS_P3:   expect_val = d_ext << 3;
      default: expect_val = d_ext;
    endcase
  end

endmodule

// File: rtl/multi_sel_rx.sv
// rtl/multi_sel_rx.sv - realigns multi_sel frames, recovers d and checks the samples
module multi_sel_rx
  import multi_sel_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_grant,
  input  logic [MS_DIN_W-1:0]  din,
  output logic [MS_D_W-1:0]    d_out,
  output logic                 d_valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ms_phase_t             state_q, state_d;
  logic [MS_D_W-1:0]     d_cap_q, d_cap_d;
  logic                  flag_q, flag_d;
  logic [MS_D_W-1:0]     d_out_q, d_out_d;
  logic                  d_valid_q, d_valid_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [MS_DIN_W-1:0]   expect_val;
  logic                  mismatch;

  multi_sel_expect u_expect (
    .d_cap      (d_cap_q),
    .phase      (state_q),
    .expect_val (expect_val)
  );

  assign mismatch = (din != expect_val);

  always_comb begin
    state_d   = state_q;
    d_cap_d   = d_cap_q;
    flag_d    = flag_q;
    d_out_d   = d_out_q;
    d_valid_d = 1'b0;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;

    if (input_grant) begin
      // A grant mid-frame closes the old frame as truncated and starts the new one.
      if (state_q != MS_IDLE) begin
        d_valid_d = 1'b1;
        d_out_d   = d_cap_q;
        err_d     = 1'b1;
      end
      d_cap_d = din[MS_D_W-1:0];
      flag_d  = |din[MS_DIN_W-1:MS_D_W];
      state_d = MS_P1;
    end else begin
      case (state_q)
        MS_P1: begin
          flag_d  = flag_q | mismatch;
          state_d = MS_P2;
        end
        MS_P2: begin
          flag_d  = flag_q | mismatch;
          state_d = MS_P3;
        end
        MS_P3: begin
          flag_d    = flag_q | mismatch;
          d_valid_d = 1'b1;
          d_out_d   = d_cap_q;
          err_d     = flag_q | mismatch;
          state_d   = MS_IDLE;
        end
        default: state_d = MS_IDLE;
      endcase
    end

    if (d_valid_d && err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MS_IDLE;
      d_cap_q   <= '0;
      flag_q    <= 1'b0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      d_cap_q   <= d_cap_d;
      flag_q    <= flag_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule
